// File: rtl/dmux_pkg.sv
// dmux_pkg: shared widths and slice helper for the 8-way 16-bit stream demux
package dmux_pkg;
    localparam int DMUX_WIDTH = 16;
    localparam int DMUX_WAYS  = 8;
    localparam int DMUX_SEL_W = 3;

    function automatic int slice_lo(input int i);
        return i * DMUX_WIDTH;
    endfunction
endpackage

// File: rtl/dmux_slot16.sv
// dmux_slot16: one-entry holding slot for a single output channel
module dmux_slot16
    import dmux_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DMUX_WIDTH-1:0] load_data,
    input  logic                  take,
    output logic                  valid,
    output logic [DMUX_WIDTH-1:0] data
);
    logic                  valid_q, valid_d;
    logic [DMUX_WIDTH-1:0] data_q, data_d;

    // a load wins over a take so drain+refill keeps the slot full
    always_comb begin
        valid_d = load ? 1'b1 : (take ? 1'b0 : valid_q);
        data_d  = load ? load_data : data_q;
    end

    // slot state register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/dmux8way16_stream.sv
// dmux8way16_stream: registered 1-to-8 valid/ready stream demux with stall counter
module dmux8way16_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int WAYS  = DMUX_WAYS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [DMUX_SEL_W-1:0] in_sel,
    output logic [WAYS-1:0]       out_valid,
    input  logic [WAYS-1:0]       out_ready,
    output logic [WIDTH*WAYS-1:0] out_data,
    output logic [15:0]           stall_cnt
);
    logic        accept;
    logic [15:0] stall_q, stall_d;

    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < WAYS; i++) begin : g_slot
        dmux_slot16 u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (accept && (in_sel == DMUX_SEL_W'(i))),
            .load_data (in_data),
            .take      (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (out_data[slice_lo(i) +: WIDTH])
        );
    end

    // count stalled cycles, saturating at all-ones
    always_comb begin
        stall_d = (in_valid && !in_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_dmux8way16_stream.sv
// tb_dmux8way16_stream: directed and random checks against a per-channel slot model
module tb_dmux8way16_stream;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [127:0] out_data;
    logic [15:0]  stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    bit          full [8];
    logic [15:0] sd [8];
    int          stall;
    bit          last_stall;
    logic [15:0] drained5 [$];

    dmux8way16_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [7:0] exp_valid();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[i] = full[i];
        return e;
    endfunction

    function automatic logic [127:0] exp_data();
        logic [127:0] e;
        for (int i = 0; i < 8; i++) e[16*i +: 16] = sd[i];
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            full[i] = 1'b0;
            sd[i]   = 16'h0;
        end
        stall = 0;
        last_stall = 1'b0;
    endtask

    // one clock cycle: drive, check in_ready, advance model at the edge, check registered outputs
    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d,
                        input logic [7:0] r, input bit ck);
        bit rdy;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #3;
        rdy = !full[s] || r[s];
        if (ck) chk("in_ready", 128'(in_ready), 128'(rdy));
        @(posedge clk);
        for (int i = 0; i < 8; i++)
            if (full[i] && r[i]) begin
                full[i] = 1'b0;
                if (i == 5) drained5.push_back(sd[i]);
            end
        if (v && rdy) begin
            full[s] = 1'b1;
            sd[s]   = d;
        end
        if (v && !rdy && stall < 65535) stall++;
        last_stall = v && !rdy;
        #1;
        if (ck) begin
            chk("out_valid", 128'(out_valid), 128'(exp_valid()));
            chk("out_data", out_data, exp_data());
            chk("stall_cnt", 128'(stall_cnt), 128'(stall));
        end
    endtask

    initial begin
        logic       hv;
        logic [2:0] hs;
        logic [15:0] hd;
        reset = 1'b1;
        in_valid = 1'b0; in_sel = 3'd0; in_data = 16'h0; out_ready = 8'h00;
        model_clear();
        #2;
        chk("rst_valid", 128'(out_valid), 128'h0);
        chk("rst_data", out_data, 128'h0);
        chk("rst_stall", 128'(stall_cnt), 128'h0);
        chk("rst_ready", 128'(in_ready), 128'h1);
        #6 reset = 1'b0;

        // single word then back-pressure on channel 3
        step(1'b1, 3'd3, 16'h1234, 8'h00, 1'b1);
        chk("ch3_word", 128'(out_data[63:48]), 128'h1234);
        chk("ch3_valid", 128'(out_valid), 128'h08);
        for (int k = 0; k < 3; k++) step(1'b1, 3'd3, 16'h5555, 8'h00, 1'b1);
        step(1'b1, 3'd3, 16'h5555, 8'h08, 1'b1);
        step(1'b0, 3'd0, 16'h0, 8'h08, 1'b1);

        // back-to-back stream through channel 5
        drained5.delete();
        for (int k = 0; k < 16; k++) step(1'b1, 3'd5, 16'hA000 + 16'(k), 8'h20, 1'b1);
        step(1'b0, 3'd0, 16'h0, 8'h20, 1'b1);
        chk("ch5_count", 128'(drained5.size()), 128'd16);
        for (int k = 0; k < 16 && k < drained5.size(); k++)
            chk("ch5_order", 128'(drained5[k]), 128'(16'hA000 + 16'(k)));

        // channel 2 blocked does not affect other channels
        step(1'b1, 3'd2, 16'h2222, 8'h00, 1'b1);
        step(1'b1, 3'd0, 16'h0F00, 8'h00, 1'b1);
        step(1'b1, 3'd1, 16'h1F11, 8'h00, 1'b1);
        step(1'b1, 3'd4, 16'h4F44, 8'h00, 1'b1);
        step(1'b1, 3'd7, 16'h7F77, 8'h00, 1'b1);
        chk("ch2_hold", 128'(out_data[47:32]), 128'h2222);
        step(1'b0, 3'd0, 16'h0, 8'hFF, 1'b1);

        // simultaneous drain and refill on channel 6
        step(1'b1, 3'd6, 16'h6666, 8'h00, 1'b1);
        step(1'b1, 3'd6, 16'hBEEF, 8'h40, 1'b1);
        chk("ch6_valid", 128'(out_valid[6]), 128'h1);
        chk("ch6_data", 128'(out_data[111:96]), 128'hBEEF);
        step(1'b0, 3'd0, 16'h0, 8'h40, 1'b1);

        // saturate the stall counter
        step(1'b1, 3'd0, 16'hC0C0, 8'h00, 1'b1);
        for (int k = 0; k < 70000; k++)
            step(1'b1, 3'd0, 16'hDDDD, 8'h00, (k % 8192 == 0) || (k > 69995));
        chk("stall_sat", 128'(stall_cnt), 128'hFFFF);
        step(1'b0, 3'd0, 16'h0, 8'h01, 1'b1);

        // asynchronous reset with channels 1 and 4 full
        step(1'b1, 3'd1, 16'h1111, 8'h00, 1'b1);
        step(1'b1, 3'd4, 16'h4444, 8'h00, 1'b1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 128'(out_valid), 128'h0);
        chk("arst_data", out_data, 128'h0);
        chk("arst_stall", 128'(stall_cnt), 128'h0);
        model_clear();
        #2 reset = 1'b0;
        step(1'b1, 3'd4, 16'h9999, 8'h00, 1'b1);
        chk("post_rst", 128'(out_valid), 128'h10);

        // randomized traffic, honouring the hold-while-stalled rule
        hv = 1'b0; hs = 3'd0; hd = 16'h0;
        for (int k = 0; k < 400; k++) begin
            if (!last_stall) begin
                hv = 1'($urandom_range(0, 1));
                hs = 3'($urandom);
                hd = 16'($urandom);
            end
            step(hv, hs, hd, 8'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmux8way16_stream.md
# dmux8way16_stream

Registered 16-bit 1-to-8 stream demultiplexor: the distribution-side counterpart of the 8-way 16-bit selector. It accepts one word per cycle on a valid/ready input tagged with a 3-bit destination and delivers it to exactly one of eight independent valid/ready output channels. Each channel has its own one-entry holding slot, so a stalled channel blocks only traffic addressed to it. It sits between a single producer, such as the CPU write path, and eight consumers, such as memory-mapped device ports.

## Interface
Parameters:
- WIDTH, 16, data width per channel
- WAYS, 8, number of output channels (fixed; sel width 3)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  16  word
- in_sel  input  3  destination channel 0..7 (000 = channel 0 ... 111 = channel 7)
- out_valid  output  8  bit i: channel i slot holds a word
- out_ready  input  8  bit i: consumer i takes the word this cycle
- out_data  output  128  channel i data at [16i+15:16i]
- stall_cnt  output  16  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
- Per channel i: slot state EMPTY or FULL; out_valid[i] = FULL; out_data slice i = slot register.
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational and depends only on the addressed channel.
- Accept (in_valid && in_ready): slot[in_sel] <= in_data and becomes FULL.
- Drain (out_valid[i] && out_ready[i]): slot i becomes EMPTY unless it is refilled in the same cycle.
- Channel i transitions:
  - EMPTY -> FULL on accept to i.
  - FULL -> EMPTY on drain without accept to i.
  - FULL -> FULL with new data on simultaneous drain and accept to i, giving a throughput of one word/cycle per channel.
  - FULL with no drain holds data and valid steady.
- Channels are independent. An accept to channel j and drains on any set of channels all occur in the same cycle.
- in_sel and in_data are ignored when in_valid=0. The producer must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
- A consumer may raise out_ready with out_valid low; this has no effect. Once raised, out_valid[i] stays high until its drain.
- stall_cnt increments by 1 per stalled cycle, saturates at 16'hFFFF, and never wraps.
- Reset mid-operation: all held words are discarded without a drain handshake.

## Timing
- Reset values: out_valid=8'h00, out_data=128'h0, stall_cnt=16'h0000. in_ready is then 1 for any in_sel.
- Latency: a word accepted at edge N appears on its channel with out_valid high after edge N, so it is drainable in cycle N+1. There is no combinational in_data -> out_data path.
- in_ready has a combinational path from out_ready[in_sel] and in_sel. out_valid and out_data are pure register outputs.
- Slot data of unselected channels never changes.

## Structure
- Package dmux_pkg:
  - constants: DMUX_WIDTH=16, DMUX_WAYS=8, DMUX_SEL_W=3
  - function slice index i -> bit offset 16i
- Sub-module dmux_slot16: one-entry register slice with inputs clk, reset, load, load_data[15:0], take, and outputs valid, data[15:0]. It is instantiated 8 times with load = accept && (in_sel==i) and take = out_ready[i].
- The top level holds the in_ready mux, the load decode, and the stall counter.

## Test plan
- Reset, then send 16'h1234 to sel 3 with out_ready=8'h00 → out_valid=8'h08 one cycle later and out_data[63:48]=16'h1234. A second word to sel 3 stalls with in_ready=0 and stall_cnt counts 1,2,3...
- Keep out_ready[5]=1 and stream 16'hA000..16'hA00F to sel 5 back-to-back → in_ready stays 1, all 16 words are drained in order, and no other out_valid bit rises.
- Hold channel 2 full with out_ready[2]=0 while sending to sels 0,1,4,7 → each is accepted immediately and channel 2 data is unchanged.
- Channel 6 full; in the same cycle raise out_ready[6]=1 and present 16'hBEEF to sel 6 → accepted, out_valid[6] stays 1, and data becomes 16'hBEEF.
- Force 70000 stalled cycles → stall_cnt=16'hFFFF and holds.
- Assert reset asynchronously with channels 1 and 4 full → out_valid=0 and data=0 immediately; after release, the first accept behaves as from a clean state.
